// File: rtl/uart_matrix_loader.sv
// uart_matrix_loader
//   Turns the uart_rx word stream into matrix-operand packets for the multiplier
//   core. A header word selects LOAD_A, LOAD_B or START. A load collects
//   ROWS*COLS elements into a store-and-forward buffer. Only completed packets
//   become visible on the AXI-Stream side. START waits until the committed data
//   has drained, then issues a one-cycle start_pulse.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   s_valid/s_data  one-cycle word strobe and word from uart_rx (no backpressure)
//   m_axis_*        packet output; tuser = 0 for matrix A, 1 for matrix B
//   start_pulse     one cycle: both operands delivered, compute may begin
//   busy            FSM not in IDLE
//   a/b_loaded      operand packet committed, START not yet issued
//   err_*           sticky error flags (overflow, timeout, command)

module uart_matrix_loader #(
  parameter int W_IN           = 24,
  parameter int ROWS           = 2,
  parameter int COLS           = 2,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  input  logic [W_IN-1:0] s_data,
  output logic            m_axis_tvalid,
  input  logic            m_axis_tready,
  output logic [W_IN-1:0] m_axis_tdata,
  output logic            m_axis_tlast,
  output logic            m_axis_tuser,
  output logic            start_pulse,
  output logic            busy,
  output logic            a_loaded,
  output logic            b_loaded,
  output logic            err_overflow,
  output logic            err_timeout,
  output logic            err_cmd
);

  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;                      // extra bit tells full from empty
  localparam int EW = W_IN + 2;                    // {sel, last, data}
  localparam int CW = $clog2(N + 1);
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] OP_LOAD_A = 8'h01;
  localparam logic [7:0] OP_LOAD_B = 8'h02;
  localparam logic [7:0] OP_START  = 8'h03;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN
  } state_t;

  state_t          state;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   commit_ptr;
  logic [CW-1:0]   elem_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            sel;

  logic [EW-1:0]   mem [FIFO_DEPTH];

  logic [7:0]      opcode;
  logic [PW-1:0]   fill;
  logic            full;
  logic            is_last;
  logic            wr_en;
  logic            pop;
  logic [EW-1:0]   rd_entry;

  assign opcode  = s_data[W_IN-1 -: 8];
  // Fill counts uncommitted words too; a pop in the same cycle is not credited.
  assign fill    = wr_ptr - rd_ptr;
  assign full    = (fill == PW'(FIFO_DEPTH));
  assign is_last = (elem_cnt == CW'(N - 1));
  assign wr_en   = (state == S_LOAD) && s_valid && !full;
  assign pop     = m_axis_tvalid && m_axis_tready;

  // First-word-fall-through read side: only committed entries are visible, and
  // an entry below commit_ptr is never overwritten, so the beat stays stable
  // while tready is low.
  assign rd_entry      = mem[rd_ptr[AW-1:0]];
  assign m_axis_tvalid = (rd_ptr != commit_ptr);
  assign m_axis_tdata  = m_axis_tvalid ? rd_entry[W_IN-1:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid & rd_entry[W_IN];
  assign m_axis_tuser  = m_axis_tvalid & rd_entry[W_IN+1];
  assign busy          = (state != S_IDLE);

  // NOTE: storage array has no reset; pointers alone define which entries are
  // meaningful, so resetting the contents would only cost logic.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {sel, is_last, s_data};
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      commit_ptr   <= '0;
      elem_cnt     <= '0;
      gap_cnt      <= '0;
      sel          <= 1'b0;
      start_pulse  <= 1'b0;
      a_loaded     <= 1'b0;
      b_loaded     <= 1'b0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
      err_cmd      <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      if (pop) rd_ptr <= rd_ptr + PW'(1);

      unique case (state)
        S_IDLE: begin
          if (s_valid) begin
            case (opcode)
              OP_LOAD_A: begin
                state    <= S_LOAD;
                elem_cnt <= '0;
                gap_cnt  <= '0;
                sel      <= 1'b0;
                a_loaded <= 1'b0;
              end
              OP_LOAD_B: begin
                state    <= S_LOAD;
                elem_cnt <= '0;
                gap_cnt  <= '0;
                sel      <= 1'b1;
                b_loaded <= 1'b0;
              end
              OP_START: begin
                if (a_loaded && b_loaded) state <= S_DRAIN;
                else                      err_cmd <= 1'b1;
              end
              default: err_cmd <= 1'b1;
            endcase
          end
        end

        S_LOAD: begin
          if (s_valid) begin
            gap_cnt <= '0;
            if (full) begin
              // Drop the word and abandon the partial packet; committed data
              // is untouched because only wr_ptr rewinds.
              wr_ptr       <= commit_ptr;
              err_overflow <= 1'b1;
              state        <= S_IDLE;
            end else begin
              wr_ptr   <= wr_ptr + PW'(1);
              elem_cnt <= elem_cnt + CW'(1);
              if (is_last) begin
                commit_ptr <= wr_ptr + PW'(1);
                if (sel) b_loaded <= 1'b1;
                else     a_loaded <= 1'b1;
                state <= S_IDLE;
              end
            end
          end else if (gap_cnt == GW'(TIMEOUT_CYCLES - 1)) begin
            wr_ptr      <= commit_ptr;
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        S_DRAIN: begin
          if (s_valid) err_cmd <= 1'b1;
          if (rd_ptr == commit_ptr) begin
            start_pulse <= 1'b1;
            a_loaded    <= 1'b0;
            b_loaded    <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_matrix_loader.sv
// Directed testbench for uart_matrix_loader. Expected beats are pushed to a
// scoreboard queue as stimulus is driven; a monitor pops and compares them on
// every accepted output beat.
module tb_uart_matrix_loader;

  localparam int W_IN = 24;

  logic            clk;
  logic            rst;
  logic            s_valid;
  logic [W_IN-1:0] s_data;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [W_IN-1:0] m_axis_tdata;
  logic            m_axis_tlast;
  logic            m_axis_tuser;
  logic            start_pulse;
  logic            busy;
  logic            a_loaded;
  logic            b_loaded;
  logic            err_overflow;
  logic            err_timeout;
  logic            err_cmd;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;
  int          wait_n;
  int          pulses;
  logic        tv_seen;

  uart_matrix_loader dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .start_pulse   (start_pulse),
    .busy          (busy),
    .a_loaded      (a_loaded),
    .b_loaded      (b_loaded),
    .err_overflow  (err_overflow),
    .err_timeout   (err_timeout),
    .err_cmd       (err_cmd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: sample on the falling edge, the handshake completes on
  // the following rising edge.
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {6'b0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, 32'hFFFF_FFFF);
      end else begin
        mon_exp = exp_q.pop_front();
        check("beat", {6'b0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, mon_exp);
      end
    end
  end

  // The initial block always sits 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [W_IN-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic load(input logic sel, input logic [W_IN-1:0] base);
    send(sel ? 24'h020000 : 24'h010000);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({6'b0, sel, (i == 3), base + W_IN'(i)});
      send(base + W_IN'(i));
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick(1);
      n++;
    end
    check(tag, exp_q.size(), 0);
    check({tag, "_tvalid_low"}, m_axis_tvalid, 0);
  endtask

  initial begin
    rst           = 1'b1;
    s_valid       = 1'b0;
    s_data        = '0;
    m_axis_tready = 1'b0;
    tick(3);
    check("reset_flags", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, start_pulse, busy,
                          a_loaded, b_loaded, err_overflow, err_timeout, err_cmd}, 0);
    check("reset_tdata", m_axis_tdata, 0);
    rst = 1'b0;
    tick(1);

    // T1: load A with tready high; nothing visible until the last element.
    m_axis_tready = 1'b1;
    send(24'h010000);
    check("t1_busy", busy, 1);
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back({6'b0, 1'b0, (i == 4), W_IN'(i)});
      send(W_IN'(i));
      if (i < 4) check("t1_tvalid_early", m_axis_tvalid, 0);
    end
    check("t1_tvalid_after_last", m_axis_tvalid, 1);
    check("t1_a_loaded", a_loaded, 1);
    check("t1_idle", busy, 0);
    drain("t1_drain");

    // T2: A and B then START; pulse only after the buffer is empty.
    load(1'b0, 24'h000100);
    load(1'b1, 24'h000200);
    check("t2_both_loaded", {a_loaded, b_loaded}, 2'b11);
    send(24'h030000);
    check("t2_drain_busy", busy, 1);
    wait_n = 0;
    while (!start_pulse && wait_n < 30) begin
      tick(1);
      wait_n++;
    end
    check("t2_start_seen", start_pulse, 1);
    check("t2_queue_empty_at_start", exp_q.size(), 0);
    check("t2_tvalid_at_start", m_axis_tvalid, 0);
    tick(1);
    check("t2_pulse_width", start_pulse, 0);
    check("t2_loaded_cleared", {a_loaded, b_loaded}, 0);
    check("t2_idle", busy, 0);

    // T5: bad opcode and premature START.
    check("t5_err_cmd_before", err_cmd, 0);
    send(24'h7F0000);
    check("t5_err_cmd", err_cmd, 1);
    check("t5_busy", busy, 0);
    send(24'h030000);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (start_pulse) pulses++;
      tick(1);
    end
    check("t5_no_start_pulse", pulses, 0);
    check("t5_busy_after_start", busy, 0);

    // T3: timeout after 2 elements; header low bits are don't-care.
    check("t3_err_timeout_before", err_timeout, 0);
    send(24'h01FFFF);
    send(24'h000011);
    send(24'h000012);
    tv_seen = 1'b0;
    for (int i = 0; i < 999; i++) begin
      tv_seen = tv_seen | m_axis_tvalid;
      tick(1);
    end
    check("t3_still_loading", busy, 1);
    check("t3_no_timeout_yet", err_timeout, 0);
    tick(1);
    check("t3_err_timeout", err_timeout, 1);
    check("t3_idle", busy, 0);
    check("t3_a_loaded", a_loaded, 0);
    check("t3_tvalid_never", tv_seen | m_axis_tvalid, 0);
    load(1'b0, 24'h000300);
    drain("t3_reload_drain");
    check("t3_reload_a_loaded", a_loaded, 1);

    // T4: overflow with tready low; committed packets survive intact.
    m_axis_tready = 1'b0;
    load(1'b0, 24'h000400);
    load(1'b1, 24'h000500);
    check("t4_tvalid", m_axis_tvalid, 1);
    tick(3);
    check("t4_head_stable", {6'b0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, 32'h0000_0400);
    check("t4_err_overflow_before", err_overflow, 0);
    send(24'h010000);
    send(24'h000999);
    check("t4_err_overflow", err_overflow, 1);
    check("t4_idle", busy, 0);
    check("t4_loaded", {a_loaded, b_loaded}, 2'b01);
    m_axis_tready = 1'b1;
    drain("t4_drain");
    tick(2);
    check("t4_no_extra_beats", m_axis_tvalid, 0);

    // T6: reset in the middle of a load.
    send(24'h010000);
    send(24'h000021);
    send(24'h000022);
    rst = 1'b1;
    tick(1);
    check("t6_reset_flags", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, start_pulse, busy,
                             a_loaded, b_loaded, err_overflow, err_timeout, err_cmd}, 0);
    check("t6_reset_tdata", m_axis_tdata, 0);
    rst = 1'b0;
    load(1'b0, 24'h000600);
    drain("t6_drain");
    check("t6_a_loaded", a_loaded, 1);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
